// File: rtl/fetch_pc.sv
// PC register and fetch sequencer with sticky misaligned/out-of-range fault.
// Define FETCH_TRACE_EN for a per-cycle $display fetch trace.
module fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [31:0] fault_pc_q;
    logic [31:0] count_q;

    logic [31:0] seq_pc;
    logic [31:0] pc_d;
    logic        advance;
    logic        misal;
    logic        oor;

    always_comb begin
        seq_pc  = pc_q + 32'd4;
        pc_d    = redirect_valid ? redirect_target : seq_pc;
        // redirect beats stall; halt beats both
        advance = !halt_req && (redirect_valid || !stall);
        misal   = (pc_d[1:0] != 2'b00);
        oor     = ({1'b0, pc_d} >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            cause_q    <= 2'b00;
            fault_pc_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (halt_req) begin
                        state_q <= HALT;
                    end else if (advance) begin
                        if (misal || oor) begin
                            state_q    <= HALT;
                            fault_q    <= 1'b1;
                            cause_q    <= misal ? 2'b01 : 2'b10;
                            fault_pc_q <= pc_d;
                        end else begin
                            pc_q    <= pc_d;
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= BOOT;
            endcase
        end
    end

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!rst && state_q == RUN) begin
            if (halt_req)
                $display("[%0t] pc=%h inst=%h HALT", $time / 10, pc_q, inst);
            else if (advance && (misal || oor))
                $display("[%0t] pc=%h inst=%h FAULT cause=%b fault_pc=%h",
                         $time / 10, pc_q, inst,
                         misal ? 2'b01 : 2'b10, pc_d);
            else if (redirect_valid)
                $display("[%0t] pc=%h inst=%h REDIR", $time / 10, pc_q, inst);
            else if (stall)
                $display("[%0t] pc=%h inst=%h STALL", $time / 10, pc_q, inst);
            else
                $display("[%0t] pc=%h inst=%h SEQ", $time / 10, pc_q, inst);
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign inst_valid  = (state_q == RUN);
    assign inst        = inst_valid ? imem_inst : NOP;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule
